operand_issue_ctrl: RTL and testbench

//  Sequences one instruction at a time through the rs1/rs2 register-read muxes.

---
 rtl/operand_issue_ctrl_if.sv | 32 +++
 rtl/operand_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_operand_issue_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/operand_issue_ctrl_if.sv
// rtl/operand_issue_ctrl_if.sv - fetch, register-read, issue and writeback signals of operand_issue_ctrl
// master is the issue controller; slave is the fetch/datapath/execution side.
interface operand_issue_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr;
    logic [3:0]        rs1_sel;
    logic [3:0]        rs2_sel;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [1:0]        unit_sel;
    logic [3:0]        issue_valid;
    logic [3:0]        issue_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [3:0]        op_rd;
    logic              wb_valid;
    logic [3:0]        wb_rd;
    logic [15:0]       busy_map;

    modport master (
        input  instr_valid, instr, rs1_data, rs2_data, issue_ready, wb_valid, wb_rd,
        output instr_ready, rs1_sel, rs2_sel, unit_sel, issue_valid, op_a, op_b, op_rd, busy_map
    );

    modport slave (
        output instr_valid, instr, rs1_data, rs2_data, issue_ready, wb_valid, wb_rd,
        input  instr_ready, rs1_sel, rs2_sel, unit_sel, issue_valid, op_a, op_b, op_rd, busy_map
    );
endinterface

// File: rtl/operand_issue_ctrl.sv
// rtl/operand_issue_ctrl.sv - single-instruction operand read/issue sequencer with busy scoreboard
// Optional stall counter port enabled by defining ISSUE_PERF_CNT_EN.
module operand_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_issue_ctrl_if.master bus
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HAZ  = 2'd1,
        S_RD   = 2'd2,
        S_ISS  = 2'd3
    } state_t;

    generate
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("CNT_W must be at least 1");
        end
    endgenerate

    state_t            state_q;
    logic [15:0]       instr_q;
    logic [15:0]       busy_q;
    logic [15:0]       busy_d;
    logic [3:0]        issue_valid_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic [3:0]        op_rd_q;

    logic [1:0]  f0;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] wb_mask;
    logic [15:0] busy_eff;
    logic        hz;
    logic        iss_hs;

    assign f0  = instr_q[15:14];
    assign rd  = instr_q[13:10];
    assign rs1 = instr_q[9:6];
    assign rs2 = instr_q[5:2];

    wire unused_instr_bits = ^instr_q[1:0];

    // A writeback landing this cycle already releases its register for the hazard check.
    assign wb_mask  = bus.wb_valid ? (16'h0001 << bus.wb_rd) : 16'h0000;
    assign busy_eff = busy_q & ~wb_mask;
    assign hz       = busy_eff[rs1] | busy_eff[rs2] | busy_eff[rd];
    assign iss_hs   = (state_q == S_ISS) && bus.issue_ready[f0];

    // The issuing destination is set after the writeback clear so a same-register writeback loses.
    always_comb begin
        busy_d = busy_eff;
        if (iss_hs) begin
            busy_d[op_rd_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            instr_q       <= '0;
            busy_q        <= '0;
            issue_valid_q <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_rd_q       <= '0;
        end else begin
            busy_q <= busy_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        state_q <= S_HAZ;
                    end
                end
                S_HAZ: begin
                    if (!hz) begin
                        state_q <= S_RD;
                    end
                end
                S_RD: begin
                    op_a_q        <= bus.rs1_data;
                    op_b_q        <= bus.rs2_data;
                    op_rd_q       <= rd;
                    issue_valid_q <= 4'b0001 << f0;
                    state_q       <= S_ISS;
                end
                S_ISS: begin
                    if (iss_hs) begin
                        issue_valid_q <= '0;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (state_q == S_IDLE) && !rst;
    assign bus.rs1_sel     = rs1;
    assign bus.rs2_sel     = rs2;
    assign bus.unit_sel    = f0;
    assign bus.issue_valid = issue_valid_q;
    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.op_rd       = op_rd_q;
    assign bus.busy_map    = busy_q;

`ifdef ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic             stall_inc;

    assign stall_inc = ((state_q == S_HAZ) && hz) ||
                       ((state_q == S_ISS) && !bus.issue_ready[f0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_issue_ctrl.sv
// tb/tb_operand_issue_ctrl.sv - randomized and directed bench for operand_issue_ctrl against a timeline model
module tb_operand_issue_ctrl;
    localparam int DW = 16;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_issue_ctrl_if #(.DATA_W(DW)) bus ();
`ifdef ISSUE_PERF_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    operand_issue_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ISSUE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    logic [DW-1:0] regs [16];
    assign bus.rs1_data = regs[bus.rs1_sel];
    assign bus.rs2_data = regs[bus.rs2_sel];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted instruction waits until no source/dest is pending, reads
    // operands one cycle later, then offers itself to unit f0 until that unit accepts.
    bit            started = 0;
    bit            m_held;
    int            m_since;
    logic [15:0]   m_instr;
    logic [15:0]   m_busy;
    logic [DW-1:0] m_a, m_b;
    logic [3:0]    m_rd;
    int            m_stall;

    task automatic bump_stall();
        if (m_stall < (1 << CW) - 1) m_stall++;
    endtask

    always @(negedge clk) begin : model_and_compare
        logic [15:0] eff, nb;
        logic [1:0]  f0;
        logic [3:0]  rd, s1, s2;
        logic [3:0]  exp_iv;
        f0 = m_instr[15:14];
        rd = m_instr[13:10];
        s1 = m_instr[9:6];
        s2 = m_instr[5:2];
        if (rst) begin
            started = 1;
            m_held = 0; m_since = -1; m_instr = '0; m_busy = '0;
            m_a = '0; m_b = '0; m_rd = '0; m_stall = 0;
        end else if (started) begin
            eff = m_busy & ~(bus.wb_valid ? (16'h0001 << bus.wb_rd) : 16'h0000);
            nb  = eff;
            if (!m_held) begin
                if (bus.instr_valid) begin
                    m_instr = bus.instr; m_held = 1; m_since = -1;
                end
            end else if (m_since < 0) begin
                if (eff[s1] | eff[s2] | eff[rd]) bump_stall();
                else m_since = 0;
            end else if (m_since == 0) begin
                m_a = regs[s1]; m_b = regs[s2]; m_rd = rd; m_since = 1;
            end else if (bus.issue_ready[f0]) begin
                nb[rd] = 1'b1; m_held = 0;
            end else begin
                bump_stall();
            end
            m_busy = nb;
        end
        if (started) begin
            exp_iv = (m_held && m_since >= 1) ? (4'b0001 << m_instr[15:14]) : 4'b0000;
            chk("instr_ready", {31'd0, bus.instr_ready}, {31'd0, (!m_held && !rst)});
            chk("issue_valid", {28'd0, bus.issue_valid}, {28'd0, exp_iv});
            chk("busy_map", {16'd0, bus.busy_map}, {16'd0, m_busy});
            chk("op_a", {16'd0, bus.op_a}, {16'd0, m_a});
            chk("op_b", {16'd0, bus.op_b}, {16'd0, m_b});
            chk("op_rd", {28'd0, bus.op_rd}, {28'd0, m_rd});
            chk("rs1_sel", {28'd0, bus.rs1_sel}, {28'd0, m_instr[9:6]});
            chk("rs2_sel", {28'd0, bus.rs2_sel}, {28'd0, m_instr[5:2]});
            chk("unit_sel", {30'd0, bus.unit_sel}, {30'd0, m_instr[15:14]});
`ifdef ISSUE_PERF_CNT_EN
            chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
`endif
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.instr_valid = 0; bus.instr = '0; bus.issue_ready = '0;
        bus.wb_valid = 0; bus.wb_rd = '0;
        for (int i = 0; i < 16; i++) regs[i] = '0;

        // T1 reset
        step(); step();
        chk("t1_busy", {16'd0, bus.busy_map}, 32'h0);
        chk("t1_iv", {28'd0, bus.issue_valid}, 32'h0);
        chk("t1_op_a", {16'd0, bus.op_a}, 32'h0);
        chk("t1_rdy_in_rst", {31'd0, bus.instr_ready}, 32'h0);
        rst = 1'b0;
        #1;
        chk("t1_rdy_after", {31'd0, bus.instr_ready}, 32'h1);

        // T2 basic issue
        regs[3] = 16'h1234; regs[5] = 16'h00FF;
        bus.issue_ready = 4'b1111;
        bus.instr_valid = 1; bus.instr = 16'h9CD4;
        step();
        bus.instr_valid = 0;
        chk("t2_rs1_sel", {28'd0, bus.rs1_sel}, 32'd3);
        step(); step();
        chk("t2_iv", {28'd0, bus.issue_valid}, 32'h4);
        chk("t2_op_a", {16'd0, bus.op_a}, 32'h1234);
        chk("t2_op_b", {16'd0, bus.op_b}, 32'h00FF);
        chk("t2_op_rd", {28'd0, bus.op_rd}, 32'd7);
        step();
        chk("t2_busy", {16'd0, bus.busy_map}, 32'h0080);
        chk("t2_iv_done", {28'd0, bus.issue_valid}, 32'h0);

        // T3 RAW on x7, then T4 backpressure
        regs[7] = 16'hBEEF; regs[1] = 16'h0A0A;
        bus.issue_ready = 4'b0000;
        bus.instr_valid = 1; bus.instr = 16'h21C4;
        step();
        bus.instr_valid = 0;
        step();
        chk("t3_rdy_haz", {31'd0, bus.instr_ready}, 32'h0);
        chk("t3_iv_haz", {28'd0, bus.issue_valid}, 32'h0);
        bus.wb_valid = 1; bus.wb_rd = 4'd7;
        step();
        bus.wb_valid = 0;
        step();
        chk("t3_iv", {28'd0, bus.issue_valid}, 32'h1);
`ifdef ISSUE_PERF_CNT_EN
        chk("t4_stall_pre", {28'd0, stall_cnt}, 32'd1);
`endif
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_iv_hold", {28'd0, bus.issue_valid}, 32'h1);
            chk("t4_op_a_hold", {16'd0, bus.op_a}, 32'hBEEF);
            chk("t4_op_b_hold", {16'd0, bus.op_b}, 32'h0A0A);
            chk("t4_op_rd_hold", {28'd0, bus.op_rd}, 32'd8);
        end
`ifdef ISSUE_PERF_CNT_EN
        chk("t4_stall_post", {28'd0, stall_cnt}, 32'd6);
`endif
        bus.issue_ready = 4'b1111;
        step();
        chk("t3_busy", {16'd0, bus.busy_map}, 32'h0100);

        // T5 reset while issuing
        bus.issue_ready = 4'b0000;
        bus.instr_valid = 1; bus.instr = 16'h9CD4;
        step();
        bus.instr_valid = 0;
        step(); step();
        chk("t5_iv", {28'd0, bus.issue_valid}, 32'h4);
        rst = 1'b1;
        step();
        chk("t5_iv_rst", {28'd0, bus.issue_valid}, 32'h0);
        chk("t5_busy_rst", {16'd0, bus.busy_map}, 32'h0);
        rst = 1'b0;
        #1;
        chk("t5_rdy", {31'd0, bus.instr_ready}, 32'h1);

        // T6 saturation of the stall counter
        bus.instr_valid = 1; bus.instr = 16'h9CD4;
        step();
        bus.instr_valid = 0;
        step(); step();
        for (int i = 0; i < 20; i++) step();
`ifdef ISSUE_PERF_CNT_EN
        chk("t6_sat", {28'd0, stall_cnt}, 32'd15);
`endif
        bus.issue_ready = 4'b1111;
        step();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.instr_valid = $urandom_range(0, 1);
            bus.instr = 16'($urandom);
            bus.issue_ready = 4'($urandom);
            bus.wb_valid = ($urandom_range(0, 9) < 4);
            bus.wb_rd = 4'($urandom);
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 15)] = 16'($urandom);
            step();
        end
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
